// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier arithmetic path.
// Holds the accumulator FSM state type, default widths and the helper
// that derives the maximum vector length from the product-count width.
package approx_mult_pkg;

  // Accumulator FSM: IDLE means the accumulator holds no partial sum.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  localparam int ACC_W_DEF = 72;
  localparam int CNT_W_DEF = 5;

  // Longest vector representable by a cnt_w-bit product counter.
  function automatic int unsigned max_len(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/approx_sat_add.sv
// Saturating accumulator adder.
// Adds a zero-extended 64-bit product to an ACC_W-wide running sum. When the
// addition carries out of ACC_W bits the sum clamps to all-ones and carry is
// raised. Purely combinational so it can sit in front of any accumulator.
// Ports:
//   acc_in  [ACC_W-1:0] : current accumulator value
//   prod_in [63:0]      : unsigned product, zero-extended to ACC_W
//   sum     [ACC_W-1:0] : saturated sum
//   carry               : addition overflowed ACC_W bits
module approx_sat_add #(
  parameter int ACC_W = 72  // must be >= 64
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [63:0]      prod_in,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W:0]   sum_full_s;

  assign prod_ext_s = ACC_W'(prod_in);
  assign sum_full_s = {1'b0, acc_in} + {1'b0, prod_ext_s};

  // Clamp to all-ones on overflow; an all-ones accumulator therefore stays
  // all-ones for any further nonzero addend.
  always_comb begin
    carry = sum_full_s[ACC_W];
    if (sum_full_s[ACC_W]) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = sum_full_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/approx_mac_acc.sv
// Vector accumulation stage behind the 32x32 approximate multiplier.
// Sums each vector of 64-bit products (closed by prod_last or by reaching
// MAX_LEN products) into a saturating accumulator, then holds the result in
// a one-deep register with a valid/ready handshake.
// Ports:
//   clk, rst (async, active-low), clk_en (global hold)
//   prod_in/prod_valid/prod_precise/prod_last/prod_ready : product input
//   sum_out/sum_count/sum_approx/sum_sat/sum_trunc       : result payload
//   sum_valid/sum_ready                                  : result handshake
module approx_mac_acc
  import approx_mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,  // must be >= 64
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [63:0]      prod_in,
  input  logic             prod_valid,
  input  logic             prod_precise,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_approx,
  output logic             sum_sat,
  output logic             sum_trunc,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(max_len(CNT_W));

  acc_state_t       state_r;
  acc_state_t       state_nxt_s;

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             approx_r;
  logic             sat_r;

  logic [ACC_W-1:0] acc_or_zero_s;
  logic [ACC_W-1:0] next_acc_s;
  logic             carry_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             approx_nxt_s;
  logic             sat_nxt_s;

  logic             prod_ready_s;
  logic             acc_fire_s;
  logic             out_fire_s;
  logic             close_s;
  logic             acc_load_s;
  logic             acc_clr_s;

  logic [ACC_W-1:0] sum_out_r;
  logic [CNT_W-1:0] sum_count_r;
  logic             sum_approx_r;
  logic             sum_sat_r;
  logic             sum_trunc_r;
  logic             sum_valid_r;

  // A full result register only blocks input when downstream is stalling,
  // so a drain and a closing product can share one cycle.
  assign prod_ready_s = clk_en & (~sum_valid_r | sum_ready);
  assign acc_fire_s   = clk_en & prod_valid & prod_ready_s;
  assign out_fire_s   = clk_en & sum_valid_r & sum_ready;

  assign count_nxt_s  = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign close_s      = prod_last | (count_nxt_s == MAX_LEN);
  assign approx_nxt_s = approx_r | ~prod_precise;
  assign sat_nxt_s    = sat_r | carry_s;

  approx_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_in  (acc_or_zero_s),
    .prod_in (prod_in),
    .sum     (next_acc_s),
    .carry   (carry_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: open a vector on a non-closing accept, return to IDLE on close.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc_fire_s && !close_s) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (acc_fire_s && close_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: adder operand select plus accumulator load/clear strobes.
  always_comb begin
    acc_or_zero_s = {ACC_W{1'b0}};
    acc_load_s    = 1'b0;
    acc_clr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        acc_or_zero_s = {ACC_W{1'b0}};
      end
      ACCUM: begin
        acc_or_zero_s = acc_r;
      end
      default: begin
        acc_or_zero_s = {ACC_W{1'b0}};
      end
    endcase
    if (acc_fire_s) begin
      acc_load_s = ~close_s;
      acc_clr_s  = close_s;
    end else begin
      acc_load_s = 1'b0;
      acc_clr_s  = 1'b0;
    end
  end

  // Running accumulator, product count and sticky flags for the open vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= {ACC_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      approx_r <= 1'b0;
      sat_r    <= 1'b0;
    end else if (acc_clr_s) begin
      acc_r    <= {ACC_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      approx_r <= 1'b0;
      sat_r    <= 1'b0;
    end else if (acc_load_s) begin
      acc_r    <= next_acc_s;
      count_r  <= count_nxt_s;
      approx_r <= approx_nxt_s;
      sat_r    <= sat_nxt_s;
    end
  end

  // One-deep result register; a close overrides a drain so there is no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_out_r    <= {ACC_W{1'b0}};
      sum_count_r  <= {CNT_W{1'b0}};
      sum_approx_r <= 1'b0;
      sum_sat_r    <= 1'b0;
      sum_trunc_r  <= 1'b0;
      sum_valid_r  <= 1'b0;
    end else if (acc_clr_s) begin
      sum_out_r    <= next_acc_s;
      sum_count_r  <= count_nxt_s;
      sum_approx_r <= approx_nxt_s;
      sum_sat_r    <= sat_nxt_s;
      sum_trunc_r  <= ~prod_last;
      sum_valid_r  <= 1'b1;
    end else if (out_fire_s) begin
      sum_valid_r  <= 1'b0;
    end
  end

  assign prod_ready = prod_ready_s;
  assign sum_out    = sum_out_r;
  assign sum_count  = sum_count_r;
  assign sum_approx = sum_approx_r;
  assign sum_sat    = sum_sat_r;
  assign sum_trunc  = sum_trunc_r;
  assign sum_valid  = sum_valid_r;

endmodule

// File: tb/tb_approx_mac_acc.sv
// Directed self-checking bench for approx_mac_acc. Two instances share all
// stimulus: dut_a uses the default 72-bit accumulator, dut_b uses a 64-bit
// accumulator so that saturation is reachable.
module tb_approx_mac_acc;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic        prod_precise;
  logic        prod_last;
  logic        sum_ready;

  logic        a_prod_ready;
  logic [71:0] a_sum_out;
  logic [4:0]  a_sum_count;
  logic        a_sum_approx;
  logic        a_sum_sat;
  logic        a_sum_trunc;
  logic        a_sum_valid;

  logic        b_prod_ready;
  logic [63:0] b_sum_out;
  logic [4:0]  b_sum_count;
  logic        b_sum_approx;
  logic        b_sum_sat;
  logic        b_sum_trunc;
  logic        b_sum_valid;

  int n_checks;
  int n_passed;

  approx_mac_acc #(.ACC_W(72), .CNT_W(5)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .prod_in      (prod_in),
    .prod_valid   (prod_valid),
    .prod_precise (prod_precise),
    .prod_last    (prod_last),
    .prod_ready   (a_prod_ready),
    .sum_out      (a_sum_out),
    .sum_count    (a_sum_count),
    .sum_approx   (a_sum_approx),
    .sum_sat      (a_sum_sat),
    .sum_trunc    (a_sum_trunc),
    .sum_valid    (a_sum_valid),
    .sum_ready    (sum_ready)
  );

  approx_mac_acc #(.ACC_W(64), .CNT_W(5)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .prod_in      (prod_in),
    .prod_valid   (prod_valid),
    .prod_precise (prod_precise),
    .prod_last    (prod_last),
    .prod_ready   (b_prod_ready),
    .sum_out      (b_sum_out),
    .sum_count    (b_sum_count),
    .sum_approx   (b_sum_approx),
    .sum_sat      (b_sum_sat),
    .sum_trunc    (b_sum_trunc),
    .sum_valid    (b_sum_valid),
    .sum_ready    (sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_passed = n_passed + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one product for one clock edge, then sample 1 time unit later.
  task automatic beat(input logic [63:0] p, input logic precise, input logic last);
    prod_in      = p;
    prod_precise = precise;
    prod_last    = last;
    prod_valid   = 1'b1;
    @(posedge clk);
    #1;
    prod_valid   = 1'b0;
    prod_last    = 1'b0;
    prod_precise = 1'b1;
  endtask

  task automatic idle();
    prod_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_passed     = 0;
    rst          = 1'b0;
    clk_en       = 1'b1;
    prod_in      = 64'd0;
    prod_valid   = 1'b0;
    prod_precise = 1'b1;
    prod_last    = 1'b0;
    sum_ready    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {127'd0, a_sum_valid}, 128'd0);
    check("rst_sum",   {56'd0, a_sum_out}, 128'd0);
    check("rst_count", {123'd0, a_sum_count}, 128'd0);
    check("rst_ready", {127'd0, a_prod_ready}, 128'd1);
    rst = 1'b1;
    idle();

    // 10 + 20 + 30, all precise
    beat(64'd10, 1'b1, 1'b0);
    check("v1_no_early_valid", {127'd0, a_sum_valid}, 128'd0);
    beat(64'd20, 1'b1, 1'b0);
    beat(64'd30, 1'b1, 1'b1);
    check("v1_valid",  {127'd0, a_sum_valid}, 128'd1);
    check("v1_sum",    {56'd0, a_sum_out}, 128'd60);
    check("v1_count",  {123'd0, a_sum_count}, 128'd3);
    check("v1_approx", {127'd0, a_sum_approx}, 128'd0);
    check("v1_sat",    {127'd0, a_sum_sat}, 128'd0);
    check("v1_trunc",  {127'd0, a_sum_trunc}, 128'd0);
    idle();
    check("v1_drained", {127'd0, a_sum_valid}, 128'd0);

    // 5 precise + 7 approximate
    beat(64'd5, 1'b1, 1'b0);
    beat(64'd7, 1'b0, 1'b1);
    check("v2_sum",    {56'd0, a_sum_out}, 128'd12);
    check("v2_count",  {123'd0, a_sum_count}, 128'd2);
    check("v2_approx", {127'd0, a_sum_approx}, 128'd1);
    idle();

    // 2**64-1 + 1: saturates in 64 bits, fits in 72 bits
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    beat(64'd1, 1'b1, 1'b1);
    check("v3_b_sum", {64'd0, b_sum_out}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    check("v3_b_sat", {127'd0, b_sum_sat}, 128'd1);
    check("v3_a_sum", {56'd0, a_sum_out}, {56'd0, 72'h01_0000_0000_0000_0000});
    check("v3_a_sat", {127'd0, a_sum_sat}, 128'd0);

    // 31 ones without prod_last: forced close at MAX_LEN
    for (int i = 0; i < 30; i++) begin
      beat(64'd1, 1'b1, 1'b0);
    end
    check("v4_open_after30", {127'd0, a_sum_valid}, 128'd0);
    beat(64'd1, 1'b1, 1'b0);
    check("v4_valid", {127'd0, a_sum_valid}, 128'd1);
    check("v4_sum",   {56'd0, a_sum_out}, 128'd31);
    check("v4_count", {123'd0, a_sum_count}, 128'd31);
    check("v4_trunc", {127'd0, a_sum_trunc}, 128'd1);
    beat(64'd4, 1'b1, 1'b1);
    check("v4_next_sum",   {56'd0, a_sum_out}, 128'd4);
    check("v4_next_count", {123'd0, a_sum_count}, 128'd1);
    check("v4_next_trunc", {127'd0, a_sum_trunc}, 128'd0);
    idle();

    // Stall: held result blocks the next last product until drained
    sum_ready = 1'b0;
    beat(64'd3, 1'b1, 1'b1);
    check("v5_first_sum", {56'd0, a_sum_out}, 128'd3);
    prod_in      = 64'd8;
    prod_precise = 1'b1;
    prod_last    = 1'b1;
    prod_valid   = 1'b1;
    #1;
    check("v5_stall_ready", {127'd0, a_prod_ready}, 128'd0);
    @(posedge clk);
    #1;
    check("v5_held_sum",   {56'd0, a_sum_out}, 128'd3);
    check("v5_held_valid", {127'd0, a_sum_valid}, 128'd1);
    sum_ready = 1'b1;
    #1;
    check("v5_release_ready", {127'd0, a_prod_ready}, 128'd1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check("v5_new_sum",   {56'd0, a_sum_out}, 128'd8);
    check("v5_new_count", {123'd0, a_sum_count}, 128'd1);
    check("v5_no_bubble", {127'd0, a_sum_valid}, 128'd1);

    // clk_en low: no accept, no drain
    clk_en       = 1'b0;
    prod_in      = 64'd100;
    prod_last    = 1'b1;
    prod_valid   = 1'b1;
    #1;
    check("ce_ready_low", {127'd0, a_prod_ready}, 128'd0);
    @(posedge clk);
    #1;
    check("ce_hold_sum",   {56'd0, a_sum_out}, 128'd8);
    check("ce_hold_valid", {127'd0, a_sum_valid}, 128'd1);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    clk_en     = 1'b1;
    idle();
    check("ce_drained", {127'd0, a_sum_valid}, 128'd0);

    // Reset mid-vector discards the partial sum
    beat(64'd50, 1'b1, 1'b0);
    beat(64'd60, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("mrst_sum",   {56'd0, a_sum_out}, 128'd0);
    check("mrst_count", {123'd0, a_sum_count}, 128'd0);
    check("mrst_valid", {127'd0, a_sum_valid}, 128'd0);
    check("mrst_ready", {127'd0, a_prod_ready}, 128'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    beat(64'd9, 1'b1, 1'b1);
    check("mrst_new_sum",    {56'd0, a_sum_out}, 128'd9);
    check("mrst_new_count",  {123'd0, a_sum_count}, 128'd1);
    check("mrst_new_approx", {127'd0, a_sum_approx}, 128'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
